// File: rtl/reg_heap_pkg.sv
// Shared types and helpers for the reg_heap register file.
package reg_heap_pkg;

  // Sequencer state; RUN is left only via reset.
  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Number of entries addressed by an addr_w-bit index.
  function automatic int unsigned depth_of(int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // LSB position of read port k inside a packed per-port bus of width w.
  function automatic int unsigned rd_lsb(int unsigned k, int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/reg_heap_init_seq.sv
// Init sequencer: after reset, clears one entry per cycle (loading the two
// preset values into entries 1 and 2), then parks in RUN and raises ready.
module reg_heap_init_seq
  import reg_heap_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INIT_R1 = 1,
  parameter int unsigned INIT_R2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic [DATA_W-1:0] init_data_o,
  output logic              ready_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk every index once; the counter holds in RUN (wraps only via reset).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun:   ;
      default: state_d = StInit;
    endcase
  end

  // Outputs: one init write per INIT cycle, presets at entries 1 and 2.
  always_comb begin
    init_we_o   = (state_q == StInit);
    init_addr_o = cnt_q;
    init_data_o = '0;
    if (cnt_q == ADDR_W'(1)) begin
      init_data_o = DATA_W'(INIT_R1);
    end else if (cnt_q == ADDR_W'(2)) begin
      init_data_o = DATA_W'(INIT_R2);
    end
    ready_o = (state_q == StRun);
  end

endmodule

// File: rtl/reg_heap_mp.sv
// Multi-read-port register file with init sequencer and per-register busy
// scoreboard bits. Define REG_HEAP_BYPASS_EN to forward same-cycle writeback
// data (and busy) onto read ports addressing the written register.
module reg_heap_mp
  import reg_heap_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned INIT_R1 = 1,
  parameter int unsigned INIT_R2 = 2
) (
  input  logic                     clk_Regs,
  input  logic                     clk_rst,
  input  logic                     Reg_Write,
  input  logic [ADDR_W-1:0]        W_Addr,
  input  logic [DATA_W-1:0]        W_Data,
  input  logic                     Rsv_En,
  input  logic [ADDR_W-1:0]        Rsv_Addr,
  input  logic [NUM_RD*ADDR_W-1:0] R_Addr,
  output logic [NUM_RD*DATA_W-1:0] R_Data,
  output logic [NUM_RD-1:0]        R_Busy,
  output logic                     Ready
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  reg_heap_init_seq #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INIT_R1 (INIT_R1),
    .INIT_R2 (INIT_R2)
  ) u_init_seq (
    .clk_i       (clk_Regs),
    .rst_i       (clk_rst),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data),
    .ready_o     (Ready)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic              wb_hit;
  logic              rsv_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Write port mux: the sequencer owns the array until Ready; entry 0 is never written in RUN.
  always_comb begin
    wb_hit    = Ready && Reg_Write && (W_Addr != '0);
    rsv_hit   = Ready && Rsv_En && (Rsv_Addr != '0);
    mem_we    = 1'b0;
    mem_waddr = W_Addr;
    mem_wdata = W_Data;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr;
      mem_wdata = init_data;
    end else if (wb_hit) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; no reset, the init sequence rewrites every entry.
  always_ff @(posedge clk_Regs) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Busy next state: writeback clears, reserve sets afterwards so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[W_Addr] = 1'b0;
    end
    if (rsv_hit) begin
      busy_d[Rsv_Addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy scoreboard register, cleared by reset.
  always_ff @(posedge clk_Regs) begin
    if (clk_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    localparam int unsigned ALsb = rd_lsb(k, ADDR_W);
    localparam int unsigned DLsb = rd_lsb(k, DATA_W);

    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    assign ra = R_Addr[ALsb +: ADDR_W];

    // Combinational read: zero while initialising and for entry 0.
    always_comb begin
      rd_data = '0;
      rd_busy = 1'b0;
      if (Ready && (ra != '0)) begin
        rd_data = mem_q[ra];
        rd_busy = busy_q[ra];
`ifdef REG_HEAP_BYPASS_EN
        if (wb_hit && (ra == W_Addr)) begin
          rd_data = W_Data;
          rd_busy = rsv_hit && (Rsv_Addr == W_Addr);
        end
`endif
      end
    end

    assign R_Data[DLsb +: DATA_W] = rd_data;
    assign R_Busy[k]              = rd_busy;
  end

endmodule

// File: tb/tb_reg_heap_mp.sv
// Scoreboard bench for reg_heap_mp: stimulus queues expected values, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_reg_heap_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  localparam int KReady = 0;
  localparam int KData  = 1;
  localparam int KBusy  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_write;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*DW-1:0]  r_data;
  logic [NR-1:0]     r_busy;
  logic              ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  reg_heap_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .INIT_R1 (1),
    .INIT_R2 (2)
  ) dut (
    .clk_Regs  (clk),
    .clk_rst   (rst),
    .Reg_Write (reg_write),
    .W_Addr    (w_addr),
    .W_Data    (w_data),
    .Rsv_En    (rsv_en),
    .Rsv_Addr  (rsv_addr),
    .R_Addr    (r_addr),
    .R_Data    (r_data),
    .R_Busy    (r_busy),
    .Ready     (ready)
  );

  // Monitor: compare every queued expectation at the negedge following its push.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = '0;
      case (e.kind)
        KReady:  act = {31'b0, ready};
        KData:   act = r_data[e.port*DW +: DW];
        default: act = {31'b0, r_busy[e.port]};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic push(input string n, input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.port = p;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    r_addr[p*AW +: AW] = a;
  endtask

  // Ready low for DEPTH cycles after release, high on the next; port0 reads 0 meanwhile.
  task automatic check_init_seq(input string tag);
    for (int c = 0; c <= 32; c++) begin
      push({tag, "_ready"}, KReady, 0, {31'b0, (c == 32)});
      if (c == 5) begin
        push({tag, "_rd_in_init"}, KData, 0, 32'h0);
        push({tag, "_busy_in_init"}, KBusy, 1, 32'h0);
      end
      if (c < 32) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; reg_write = 1'b0; w_addr = '0; w_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; r_addr = '0;

    // Reset and first init sequence.
    tick();
    push("ready_in_reset", KReady, 0, 32'h0);
    tick();
    rst = 1'b0;
    set_ra(0, 5'd1);
    set_ra(1, 5'd2);
    check_init_seq("init1");
    push("r1_preset", KData, 0, 32'h1);
    push("r2_preset", KData, 1, 32'h2);
    tick();
    set_ra(0, 5'd31);
    set_ra(1, 5'd0);
    push("r31_zero", KData, 0, 32'h0);
    push("r0_zero", KData, 1, 32'h0);

    // Write r5, visible next cycle.
    reg_write = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
    set_ra(0, 5'd5);
`ifdef REG_HEAP_BYPASS_EN
    push("r5_same_cycle", KData, 0, 32'hDEADBEEF);
`else
    push("r5_same_cycle", KData, 0, 32'h0);
`endif
    tick();
    reg_write = 1'b0;
    push("r5_written", KData, 0, 32'hDEADBEEF);

    // Write to r0 ignored.
    reg_write = 1'b1; w_addr = 5'd0; w_data = 32'h1234;
    tick();
    reg_write = 1'b0;
    set_ra(0, 5'd0);
    push("r0_write_ignored", KData, 0, 32'h0);

    // Reserve r7, then writeback clears busy.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    set_ra(1, 5'd7);
    push("r7_busy_before", KBusy, 1, 32'h0);
    tick();
    rsv_en = 1'b0;
    set_ra(0, 5'd7);
    push("r7_busy_p1", KBusy, 1, 32'h1);
    push("r7_busy_p0", KBusy, 0, 32'h1);
    reg_write = 1'b1; w_addr = 5'd7; w_data = 32'h55;
    tick();
    reg_write = 1'b0;
    push("r7_busy_cleared", KBusy, 1, 32'h0);
    push("r7_data", KData, 1, 32'h55);

    // Same-cycle write and reserve of r9: reserve wins.
    reg_write = 1'b1; w_addr = 5'd9; w_data = 32'h99;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_ra(0, 5'd9);
`ifdef REG_HEAP_BYPASS_EN
    push("r9_fwd_data", KData, 0, 32'h99);
    push("r9_fwd_busy", KBusy, 0, 32'h1);
`else
    push("r9_old_data", KData, 0, 32'h0);
    push("r9_old_busy", KBusy, 0, 32'h0);
`endif
    tick();
    reg_write = 1'b0; rsv_en = 1'b0;
    push("r9_data", KData, 0, 32'h99);
    push("r9_busy", KBusy, 0, 32'h1);

    // Write r3 while port1 reads it.
    reg_write = 1'b1; w_addr = 5'd3; w_data = 32'hA5;
    set_ra(1, 5'd3);
`ifdef REG_HEAP_BYPASS_EN
    push("r3_bypass", KData, 1, 32'hA5);
`else
    push("r3_no_bypass", KData, 1, 32'h0);
`endif
    push("r3_busy", KBusy, 1, 32'h0);
    tick();
    reg_write = 1'b0;
    push("r3_data", KData, 1, 32'hA5);

    // Reserve of r0 ignored.
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_ra(0, 5'd0);
    tick();
    rsv_en = 1'b0;
    push("r0_busy", KBusy, 0, 32'h0);

    // Reset during INIT cycle 10 restarts the count.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ra(0, 5'd1);
    set_ra(1, 5'd2);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_init_seq("init_restart");
    push("restart_r1", KData, 0, 32'h1);
    tick();

    // Reserve r4 so busy bits are set, then reset in RUN with writes/reserves held.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_en = 1'b0;
    set_ra(0, 5'd4);
    push("r4_busy_set", KBusy, 0, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reg_write = 1'b1; w_addr = 5'd6; w_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    set_ra(0, 5'd1);
    set_ra(1, 5'd4);
    check_init_seq("init_run_rst");
    reg_write = 1'b0; rsv_en = 1'b0;
    push("r4_busy_cleared", KBusy, 1, 32'h0);
    push("r1_after_rst", KData, 0, 32'h1);
    tick();
    set_ra(0, 5'd6);
    set_ra(1, 5'd5);
    push("r6_write_ignored", KData, 0, 32'h0);
    push("r6_rsv_ignored", KBusy, 0, 32'h0);
    push("r5_cleared", KData, 1, 32'h0);
    set_ra(1, 5'd9);
    #1;
    push("r9_busy_cleared", KBusy, 1, 32'h0);
    tick();
    tick();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
